branch_target_predictor: RTL and testbench

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

---
 rtl/branch_target_predictor_pkg.sv | 38 +++
 rtl/branch_target_predictor_sat_counter2.sv | 26 ++
 rtl/branch_target_predictor.sv | 122 ++++++++++++
 tb/tb_branch_target_predictor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : BasicTypes / PipelineTypes (packages)
// Brief    : Shared types for the branch target predictor: the PC type, the
//            2-bit direction counter and the BTB entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package BasicTypes;

  typedef logic [31:0] PC_t;

endpackage

package PipelineTypes;
  import BasicTypes::*;

  // 2-bit saturating direction counter: 00 SNT, 01 WNT, 10 WT, 11 ST
  typedef logic [1:0] PhtCounter_t;

  localparam PhtCounter_t PHT_STRONG_NT = 2'b00;
  localparam PhtCounter_t PHT_WEAK_NT   = 2'b01;
  localparam PhtCounter_t PHT_STRONG_T  = 2'b11;

  // The tag is kept at full PC width (PC shifted right by index+offset bits)
  // so the struct does not depend on the table size parameter.
  typedef struct packed {
    logic valid;
    PC_t  tag;
    PC_t  target;
  } BtbEntry_t;

  // Tag of a PC for a table indexed by index_bits bits above the byte offset.
  function automatic PC_t pc_tag(input PC_t pc, input int unsigned index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter2
// Brief    : Next-state logic of a 2-bit saturating up/down counter.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter2
  import PipelineTypes::*;
(
  input  PhtCounter_t cnt_i,
  input  logic        inc_i,
  output PhtCounter_t cnt_o
);

  // Step toward taken or not-taken, holding at the end states
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != PHT_STRONG_T) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != PHT_STRONG_NT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_predictor
// Brief    : Direct-mapped PHT (2-bit counters) plus BTB with zero-latency
//            lookup, execute-stage update and debug statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_predictor
  import BasicTypes::*;
  import PipelineTypes::*;
#(
  parameter int ENTRY_NUM  = 64,
  parameter int INDEX_BITS = $clog2(ENTRY_NUM)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchPc,
  output logic        isBranchTakenPredicted,
  output logic        btbHit,
  output logic [31:0] btbPredictedPc,
  input  logic        updValid,
  input  logic [31:0] updPc,
  input  logic        updIsTaken,
  input  logic [31:0] updTarget,
  output logic [31:0] lookupCount,
  output logic [31:0] missCount
);

  PhtCounter_t pht_q [ENTRY_NUM];
  BtbEntry_t   btb_q [ENTRY_NUM];

  logic [INDEX_BITS-1:0] fetchIdx;
  logic [INDEX_BITS-1:0] updIdx;
  PC_t                   fetchTag;
  PC_t                   updTag;

  assign fetchIdx = fetchPc[INDEX_BITS+1:2];
  assign updIdx   = updPc[INDEX_BITS+1:2];
  assign fetchTag = pc_tag(fetchPc, INDEX_BITS);
  assign updTag   = pc_tag(updPc, INDEX_BITS);

  BtbEntry_t fetchEntry;

  // Lookup reads the registered tables only, so a same-cycle update is not seen
  always_comb begin
    fetchEntry             = btb_q[fetchIdx];
    isBranchTakenPredicted = pht_q[fetchIdx][1];
    btbHit                 = fetchEntry.valid && (fetchEntry.tag == fetchTag);
    btbPredictedPc         = btbHit ? fetchEntry.target : 32'd0;
  end

  PhtCounter_t updCnt;
  PhtCounter_t pht_d;
  BtbEntry_t   updEntry;
  BtbEntry_t   btb_d;
  logic        updPredTaken;
  logic        updTargetOk;
  logic        updMispredict;

  sat_counter2 u_sat_counter2 (
    .cnt_i (updCnt),
    .inc_i (updIsTaken),
    .cnt_o (pht_d)
  );

  // Judge the stored prediction for the resolved PC and build the new BTB entry
  always_comb begin
    updCnt        = pht_q[updIdx];
    updEntry      = btb_q[updIdx];
    updPredTaken  = updCnt[1];
    updTargetOk   = updEntry.valid && (updEntry.tag == updTag) &&
                    (updEntry.target == updTarget);
    updMispredict = (updPredTaken != updIsTaken) || (updIsTaken && !updTargetOk);
    btb_d.valid   = 1'b1;
    btb_d.tag     = updTag;
    btb_d.target  = updTarget;
  end

  // Direction counters: every resolved branch trains its entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) pht_q[i] <= PHT_WEAK_NT;
    end else if (updValid) begin
      pht_q[updIdx] <= pht_d;
    end
  end

  // Target buffer: only taken branches allocate/replace their entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) btb_q[i] <= '0;
    end else if (updValid && updIsTaken) begin
      btb_q[updIdx] <= btb_d;
    end
  end

  logic [31:0] lookupCount_q, lookupCount_d;
  logic [31:0] missCount_q, missCount_d;

  // Statistics next-state; both wrap naturally at 32 bits
  always_comb begin
    lookupCount_d = lookupCount_q + 32'd1;
    missCount_d   = missCount_q;
    if (updValid && updMispredict) missCount_d = missCount_q + 32'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookupCount_q <= 32'd0;
      missCount_q   <= 32'd0;
    end else begin
      lookupCount_q <= lookupCount_d;
      missCount_q   <= missCount_d;
    end
  end

  assign lookupCount = lookupCount_q;
  assign missCount   = missCount_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_predictor
// Brief    : Self-checking bench for branch_target_predictor with an
//            array-based reference model of the predictor tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

  localparam int N = 64;

  logic        clk;
  logic        rst;
  logic [31:0] fetchPc;
  logic        isBranchTakenPredicted;
  logic        btbHit;
  logic [31:0] btbPredictedPc;
  logic        updValid;
  logic [31:0] updPc;
  logic        updIsTaken;
  logic [31:0] updTarget;
  logic [31:0] lookupCount;
  logic [31:0] missCount;

  int n_cmp = 0;
  int n_bad = 0;

  branch_target_predictor #(.ENTRY_NUM(N)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .fetchPc                (fetchPc),
    .isBranchTakenPredicted (isBranchTakenPredicted),
    .btbHit                 (btbHit),
    .btbPredictedPc         (btbPredictedPc),
    .updValid               (updValid),
    .updPc                  (updPc),
    .updIsTaken             (updIsTaken),
    .updTarget              (updTarget),
    .lookupCount            (lookupCount),
    .missCount              (missCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counter value 0..3, valid flag, full-PC tag, target
  int          m_cnt [N];
  bit          m_val [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  logic [31:0] m_lookups;
  logic [31:0] m_misses;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 1;
      m_val[i] = 0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
    m_lookups = '0;
    m_misses  = '0;
  endtask

  function automatic bit exp_taken(input logic [31:0] pc);
    return m_cnt[midx(pc)] >= 2;
  endfunction

  function automatic bit exp_hit(input logic [31:0] pc);
    return m_val[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic logic [31:0] exp_tgt(input logic [31:0] pc);
    return exp_hit(pc) ? m_tgt[midx(pc)] : 32'd0;
  endfunction

  // Model advances on each clock edge out of reset
  always @(posedge clk) begin
    if (!rst) begin
      m_lookups = m_lookups + 32'd1;
      if (updValid) begin
        int  i;
        bit  pred;
        bit  tgt_ok;
        i      = midx(updPc);
        pred   = m_cnt[i] >= 2;
        tgt_ok = m_val[i] && (m_tag[i] == mtag(updPc)) && (m_tgt[i] == updTarget);
        if ((pred != updIsTaken) || (updIsTaken && !tgt_ok)) m_misses = m_misses + 32'd1;
        if (updIsTaken) begin
          if (m_cnt[i] < 3) m_cnt[i] = m_cnt[i] + 1;
          m_val[i] = 1;
          m_tag[i] = mtag(updPc);
          m_tgt[i] = updTarget;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    updValid   = v;
    updPc      = pc;
    updIsTaken = tk;
    updTarget  = tg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    fetchPc = 32'h100;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    n_cmp++; if (isBranchTakenPredicted !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %0b want 0", isBranchTakenPredicted); end
    n_cmp++; if (btbHit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %0b want 0", btbHit); end
    n_cmp++; if (btbPredictedPc !== 32'd0) begin n_bad++; $display("FAIL reset_target: got %h want 0", btbPredictedPc); end
    n_cmp++; if (lookupCount !== 32'd0) begin n_bad++; $display("FAIL reset_lookups: got %0d want 0", lookupCount); end
    n_cmp++; if (missCount !== 32'd0) begin n_bad++; $display("FAIL reset_misses: got %0d want 0", missCount); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_update();
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetchPc = 32'h100;
    #1;
    n_cmp++; if (isBranchTakenPredicted !== 1'b1) begin n_bad++; $display("FAIL single_taken: got %0b want 1", isBranchTakenPredicted); end
    n_cmp++; if (btbHit !== 1'b1) begin n_bad++; $display("FAIL single_hit: got %0b want 1", btbHit); end
    n_cmp++; if (btbPredictedPc !== 32'h200) begin n_bad++; $display("FAIL single_target: got %h want 200", btbPredictedPc); end
    n_cmp++; if (missCount !== 32'd1) begin n_bad++; $display("FAIL single_misses: got %0d want 1", missCount); end
    n_cmp++; if (lookupCount !== m_lookups) begin n_bad++; $display("FAIL single_lookups: got %0d want %0d", lookupCount, m_lookups); end
  endtask

  task automatic test_saturation();
    fetchPc = 32'h100;
    for (int k = 0; k < 4; k++) begin
      set_upd(1'b1, 32'h100, 1'b1, 32'h200);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      set_upd(1'b1, 32'h100, 1'b0, 32'h0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      n_cmp++;
      if (isBranchTakenPredicted !== (k == 0)) begin
        n_bad++;
        $display("FAIL sat_taken_after_nt%0d: got %0b want %0b", k + 1, isBranchTakenPredicted, k == 0);
      end
    end
    n_cmp++; if (btbHit !== 1'b1) begin n_bad++; $display("FAIL sat_hit: got %0b want 1", btbHit); end
    n_cmp++; if (btbPredictedPc !== 32'h200) begin n_bad++; $display("FAIL sat_target: got %h want 200", btbPredictedPc); end
    n_cmp++; if (missCount !== m_misses) begin n_bad++; $display("FAIL sat_misses: got %0d want %0d", missCount, m_misses); end
  endtask

  task automatic test_conflict();
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    tick();
    set_upd(1'b1, 32'h200, 1'b1, 32'h300);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetchPc = 32'h100;
    #1;
    n_cmp++; if (btbHit !== 1'b0) begin n_bad++; $display("FAIL conflict_old_hit: got %0b want 0", btbHit); end
    n_cmp++; if (btbPredictedPc !== 32'd0) begin n_bad++; $display("FAIL conflict_old_target: got %h want 0", btbPredictedPc); end
    fetchPc = 32'h200;
    #1;
    n_cmp++; if (btbHit !== 1'b1) begin n_bad++; $display("FAIL conflict_new_hit: got %0b want 1", btbHit); end
    n_cmp++; if (btbPredictedPc !== 32'h300) begin n_bad++; $display("FAIL conflict_new_target: got %h want 300", btbPredictedPc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fetchPc = 32'h100;
    set_upd(1'b1, 32'h100, 1'b1, 32'h200);
    #1;
    n_cmp++; if (isBranchTakenPredicted !== 1'b0) begin n_bad++; $display("FAIL same_cycle_taken: got %0b want 0", isBranchTakenPredicted); end
    n_cmp++; if (btbHit !== 1'b0) begin n_bad++; $display("FAIL same_cycle_hit: got %0b want 0", btbHit); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (isBranchTakenPredicted !== 1'b1) begin n_bad++; $display("FAIL next_cycle_taken: got %0b want 1", isBranchTakenPredicted); end
    n_cmp++; if (btbHit !== 1'b1) begin n_bad++; $display("FAIL next_cycle_hit: got %0b want 1", btbHit); end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] idx, tg, lo;
    idx = 32'($urandom_range(0, 7));
    tg  = 32'($urandom_range(0, 2));
    lo  = 32'($urandom_range(0, 3));
    return (tg << 8) | (idx << 2) | lo;
  endfunction

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int c = 0; c < 300; c++) begin
      fetchPc = rand_pc();
      set_upd($urandom_range(0, 9) < 6, rand_pc(), 1'($urandom_range(0, 1)),
              32'h1000 + 32'($urandom_range(0, 3)) * 32'd4);
      #1;
      n_cmp++;
      if (isBranchTakenPredicted !== exp_taken(fetchPc)) begin
        n_bad++;
        $display("FAIL rand_taken c%0d pc=%h: got %0b want %0b", c, fetchPc, isBranchTakenPredicted, exp_taken(fetchPc));
      end
      n_cmp++;
      if (btbHit !== exp_hit(fetchPc) || btbPredictedPc !== exp_tgt(fetchPc)) begin
        n_bad++;
        $display("FAIL rand_btb c%0d pc=%h: got hit=%0b tgt=%h want hit=%0b tgt=%h", c, fetchPc,
                 btbHit, btbPredictedPc, exp_hit(fetchPc), exp_tgt(fetchPc));
      end
      n_cmp++;
      if (lookupCount !== m_lookups || missCount !== m_misses) begin
        n_bad++;
        $display("FAIL rand_stats c%0d: got lookups=%0d misses=%0d want lookups=%0d misses=%0d", c,
                 lookupCount, missCount, m_lookups, m_misses);
      end
      if (n_bad - bad_before > 5) break;
      tick();
    end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_async_reset();
    fetchPc = 32'h100;
    for (int k = 0; k < 3; k++) begin
      set_upd(1'b1, 32'h100, 1'b1, 32'h200);
      tick();
    end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (btbHit !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hit: got %0b want 1", btbHit); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (isBranchTakenPredicted !== 1'b0) begin n_bad++; $display("FAIL async_taken: got %0b want 0", isBranchTakenPredicted); end
    n_cmp++; if (btbHit !== 1'b0 || btbPredictedPc !== 32'd0) begin n_bad++; $display("FAIL async_btb: got hit=%0b tgt=%h want 0/0", btbHit, btbPredictedPc); end
    n_cmp++; if (lookupCount !== 32'd0 || missCount !== 32'd0) begin n_bad++; $display("FAIL async_stats: got %0d/%0d want 0/0", lookupCount, missCount); end
    set_upd(1'b1, 32'h100, 1'b1, 32'h240);
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (btbHit !== 1'b0) begin n_bad++; $display("FAIL discarded_update_hit: got %0b want 0", btbHit); end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (btbHit !== 1'b1 || btbPredictedPc !== 32'h240) begin n_bad++; $display("FAIL first_update_btb: got hit=%0b tgt=%h want 1/240", btbHit, btbPredictedPc); end
    n_cmp++; if (isBranchTakenPredicted !== 1'b1) begin n_bad++; $display("FAIL first_update_taken: got %0b want 1", isBranchTakenPredicted); end
    n_cmp++; if (lookupCount !== 32'd1) begin n_bad++; $display("FAIL first_update_lookups: got %0d want 1", lookupCount); end
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_saturation();
    test_conflict();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
